expr_eval: RTL

- Arithmetic evaluator that runs alongside the character-stream syntax checker (`expr`).
- Consumes the same one-ASCII-character-per-cycle stream: single digits '0'-'9' separated by '+' or '*'.
- Computes the integer value of the expression, with '*' binding tighter than '+'.
- Reports the running value, a well-formed flag, a sticky error flag and a sticky overflow flag to downstream display/compare logic.

---
 rtl/expr_eval_pkg.sv | 15 +
 rtl/expr_char_class.sv | 22 ++
 rtl/expr_eval.sv | 98 +++++++++
 3 files changed

// File: rtl/expr_eval_pkg.sv
// rtl/expr_eval_pkg.sv - character constants and FSM encoding shared with the expr syntax checker
package expr_eval_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

  typedef enum logic [1:0] {
    S_NUM = 2'd0,
    S_OP  = 2'd1,
    S_ERR = 2'd2
  } expr_state_e;

endpackage

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - combinational classifier for one ASCII expression character
module expr_char_class
  import expr_eval_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic       is_plus,
  output logic       is_mul,
  output logic       is_bad,
  output logic [3:0] digit
);

  always_comb begin
    is_digit = (in >= CH_0) && (in <= CH_9);
    is_plus  = (in == CH_PLUS);
    is_mul   = (in == CH_MUL);
    is_bad   = !(is_digit || is_plus || is_mul);
    // '0'..'9' are 0x30..0x39, so the low nibble is the digit value
    digit    = is_digit ? in[3:0] : 4'd0;
  end

endmodule

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - evaluates a digit/'+'/'*' character stream with '*' binding tighter than '+'
module expr_eval
  import expr_eval_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_vld,
  input  logic [7:0]   in,
  output logic         ok,
  output logic         err,
  output logic         ovf,
  output logic [W-1:0] value
);

  expr_state_e  state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] prod_q, prod_d;
  logic [W-1:0] value_q, value_d;
  logic         ovf_q, ovf_d;

  logic         is_digit, is_plus, is_mul, is_bad;
  logic [3:0]   digit;
  logic [2*W-1:0] p_full;
  logic [W:0]     s_full;

  expr_char_class u_char_class (
    .in       (in),
    .is_digit (is_digit),
    .is_plus  (is_plus),
    .is_mul   (is_mul),
    .is_bad   (is_bad),
    .digit    (digit)
  );

  // Wide product and carry-extended sum expose overflow before truncation
  always_comb begin
    p_full = (2*W)'(prod_q) * (2*W)'(digit);
    s_full = (W+1)'(sum_q) + (W+1)'(p_full[W-1:0]);
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    if (in_vld) begin
      case (state_q)
        S_NUM: begin
          if (is_digit) begin
            state_d = S_OP;
            prod_d  = p_full[W-1:0];
            value_d = s_full[W-1:0];
            if ((|p_full[2*W-1:W]) || s_full[W]) ovf_d = 1'b1;
          end else if (is_plus || is_mul || is_bad) begin
            state_d = S_ERR;
          end
        end
        S_OP: begin
          if (is_plus) begin
            state_d = S_NUM;
            sum_d   = sum_q + prod_q;
            prod_d  = W'(1);
          end else if (is_mul) begin
            state_d = S_NUM;
          end else begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_NUM;
      sum_q   <= '0;
      prod_q  <= W'(1);
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      prod_q  <= prod_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ok    = (state_q == S_OP);
  assign err   = (state_q == S_ERR);
  assign ovf   = ovf_q;
  assign value = value_q;

endmodule
